// File: rtl/mem_scan_viewer_pkg.sv
// Shared types for the scan-read memory viewer.
// The scan mode encoding matches the two-bit board switch field.
package mem_scan_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        AUTO    = 2'b01,
        STEP    = 2'b10,
        ONESHOT = 2'b11
    } scan_mode_t;

    localparam int DEF_DATA_W   = 3;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_TICK_DIV = 50_000_000;

endpackage

// File: rtl/mem_scan_viewer_if.sv
// Board-control and scan-read bundle between the SW/KEY decode and the viewer.
// The control side is the master, the viewer is the slave.
interface mem_scan_viewer_if #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 5
);
    import mem_scan_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    scan_mode_t        mode;
    logic              step;
    logic              clear_ptr;

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wrapped;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, mode, step, clear_ptr,
        input  rd_addr, rd_data, rd_valid, wrapped, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, mode, step, clear_ptr,
        output rd_addr, rd_data, rd_valid, wrapped, done
    );

endinterface

// File: rtl/mem_scan_viewer_dp_ram_sync.sv
// One-write/one-read synchronous RAM with registered output.
// A write to the address being read is forwarded to q on the same edge.
module dp_ram_sync #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_q
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Array has no reset so it maps onto block RAM; only the output register clears.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (i_we && (i_waddr == i_raddr)) begin
            r_q <= i_wdata;
        end else begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_scan_viewer.sv
// Dual-port memory whose read address is walked by an internal scanner
// (hold, timed auto, manual step, or a single timed pass that stops at the top).
module mem_scan_viewer
    import mem_scan_pkg::*;
#(
    parameter int DATA_W   = 3,
    parameter int ADDR_W   = 5,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_scan_viewer_if.slave bus
);

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]     r_tick_cnt;
    logic              r_step_q;
    scan_mode_t        r_mode_q;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_valid;
    logic              r_wrapped;
    logic              r_done;

    logic              w_mode_chg;
    logic              w_at_last;
    logic              w_tick_hit;
    logic              w_adv;
    logic [ADDR_W-1:0] w_addr_next;
    logic [DATA_W-1:0] w_rd_data;

    always_comb begin
        w_mode_chg = (bus.mode != r_mode_q);
        w_at_last  = &r_rd_addr;
        // A mode change restarts the timer, so a timed advance cannot land on that edge.
        w_tick_hit = !w_mode_chg && (r_tick_cnt == TICK_LAST);
        w_adv      = 1'b0;
        case (bus.mode)
            AUTO:    w_adv = w_tick_hit;
            STEP:    w_adv = bus.step && !r_step_q;
            ONESHOT: w_adv = w_tick_hit && !w_at_last;
            default: w_adv = 1'b0;
        endcase
        if (bus.clear_ptr) begin
            w_addr_next = '0;
        end else if (w_adv) begin
            w_addr_next = r_rd_addr + 1'b1;
        end else begin
            w_addr_next = r_rd_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
            r_step_q   <= 1'b0;
            r_mode_q   <= HOLD;
            r_rd_addr  <= '0;
            r_rd_valid <= 1'b0;
            r_wrapped  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_step_q   <= bus.step;
            r_mode_q   <= bus.mode;
            r_rd_addr  <= w_addr_next;
            r_rd_valid <= (w_addr_next == r_rd_addr);
            r_wrapped  <= w_adv && w_at_last && !bus.clear_ptr;

            if (bus.clear_ptr || w_mode_chg) begin
                r_tick_cnt <= '0;
            end else begin
                case (bus.mode)
                    AUTO:    r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
                    ONESHOT: r_tick_cnt <= (w_at_last || r_tick_cnt == TICK_LAST) ? '0
                                                                                 : r_tick_cnt + 1'b1;
                    default: r_tick_cnt <= '0;
                endcase
            end

            if (bus.clear_ptr || bus.mode != ONESHOT) begin
                r_done <= 1'b0;
            end else if (w_at_last) begin
                r_done <= 1'b1;
            end
        end
    end

    dp_ram_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (bus.wr_en),
        .i_waddr (bus.wr_addr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_addr),
        .o_q     (w_rd_data)
    );

    assign bus.rd_addr  = r_rd_addr;
    assign bus.rd_data  = w_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.wrapped  = r_wrapped;
    assign bus.done     = r_done;

endmodule
